adsr_poly: RTL and testbench

ADSR_POLY -- requirements
Module: adsr_poly

---
 rtl/adsr_poly.sv | 173 +++++++++++++++++
 tb/tb_adsr_poly.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adsr_poly.sv
// adsr_poly: time-multiplexed ADSR envelope generator. One shared datapath
// services every voice in turn after each sample tick. Per-voice state, level
// and previous gate are held in arrays indexed by the voice number.
//
// out_valid is a one-cycle qualifier for out/out_voice. There is no ready or
// backpressure: a consumer must take the word in the cycle it is valid.
module adsr_poly #(
    parameter int TOTAL_BITS      = 48,
    parameter int FRACTIONAL_BITS = 32,
    parameter int VOICES          = 8,
    localparam int VB             = $clog2(VOICES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [TOTAL_BITS-1:0] a,
    input  logic signed [TOTAL_BITS-1:0] d,
    input  logic signed [TOTAL_BITS-1:0] s,
    input  logic signed [TOTAL_BITS-1:0] r,
    input  logic        [VOICES-1:0]     gate,
    input  logic                         retrigger,
    input  logic                         tick,
    output logic signed [TOTAL_BITS-1:0] out,
    output logic        [VB-1:0]         out_voice,
    output logic                         out_valid,
    output logic        [VOICES-1:0]     active,
    output logic                         busy,
    output logic                         overrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } voice_state_t;

    // Arithmetic runs one bit wider than the level words so sums never wrap.
    localparam logic signed [TOTAL_BITS:0] ONE_W =
        {{(TOTAL_BITS - FRACTIONAL_BITS){1'b0}}, 1'b1, {FRACTIONAL_BITS{1'b0}}};
    localparam logic signed [TOTAL_BITS:0] ZERO_W = '0;
    localparam logic [VB-1:0] LAST_VOICE = VB'(VOICES - 1);

    voice_state_t                 state_q [VOICES];
    logic signed [TOTAL_BITS-1:0] level_q [VOICES];
    logic [VOICES-1:0]            prev_q;
    logic [VB-1:0]                idx_q;
    logic                         busy_q;
    logic                         overrun_q;
    logic signed [TOTAL_BITS-1:0] out_q;
    logic [VB-1:0]                out_voice_q;
    logic                         out_valid_q;
    logic [VOICES-1:0]            active_q;

    voice_state_t             cur_state, mid_state, next_state;
    logic signed [TOTAL_BITS:0] cur_level, mid_level, next_level;
    logic signed [TOTAL_BITS:0] wa, wd, wr, ws, s_c;
    logic signed [TOTAL_BITS:0] sum_a, diff_d, diff_r;
    logic                     gate_now, prev_now, rise, fall;

    // Next state and level for the voice being serviced this cycle.
    always_comb begin
        wa        = {a[TOTAL_BITS-1], a};
        wd        = {d[TOTAL_BITS-1], d};
        wr        = {r[TOTAL_BITS-1], r};
        ws        = {s[TOTAL_BITS-1], s};
        cur_state = state_q[idx_q];
        cur_level = {level_q[idx_q][TOTAL_BITS-1], level_q[idx_q]};
        gate_now  = gate[idx_q];
        prev_now  = prev_q[idx_q];
        // A voice left idle with its gate already high (e.g. gate held
        // through reset) starts as if the gate had just risen.
        rise      = gate_now && (!prev_now || cur_state == ST_IDLE);
        fall      = !gate_now && prev_now &&
                    (cur_state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN});

        if (ws < ZERO_W)      s_c = ZERO_W;
        else if (ws > ONE_W)  s_c = ONE_W;
        else                  s_c = ws;

        mid_state = cur_state;
        mid_level = cur_level;
        if (rise) begin
            mid_state = ST_ATTACK;
            if (retrigger) mid_level = ZERO_W;
        end else if (fall) begin
            mid_state = ST_RELEASE;
        end

        sum_a  = mid_level + wa;
        diff_d = mid_level - wd;
        diff_r = mid_level - wr;

        next_state = mid_state;
        next_level = mid_level;
        case (mid_state)
            ST_ATTACK: begin
                if (wa <= ZERO_W || sum_a >= ONE_W) begin
                    next_level = ONE_W;
                    next_state = ST_DECAY;
                end else begin
                    next_level = sum_a;
                end
            end
            ST_DECAY: begin
                if (wd <= ZERO_W || diff_d <= s_c) begin
                    next_level = s_c;
                    next_state = ST_SUSTAIN;
                end else begin
                    next_level = diff_d;
                end
            end
            ST_SUSTAIN: next_level = s_c;
            ST_RELEASE: begin
                if (wr <= ZERO_W || diff_r <= ZERO_W) begin
                    next_level = ZERO_W;
                    next_state = ST_IDLE;
                end else begin
                    next_level = diff_r;
                end
            end
            default: begin
                next_level = ZERO_W;
                next_state = ST_IDLE;
            end
        endcase
    end

    // Sweep sequencing, per-voice state registers and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < VOICES; v++) begin
                state_q[v] <= ST_IDLE;
                level_q[v] <= '0;
            end
            prev_q      <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            out_q       <= '0;
            out_voice_q <= '0;
            out_valid_q <= 1'b0;
            active_q    <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (tick && busy_q) overrun_q <= 1'b1;
            if (!busy_q) begin
                if (tick) begin
                    busy_q <= 1'b1;
                    idx_q  <= '0;
                end
            end else begin
                state_q[idx_q]  <= next_state;
                level_q[idx_q]  <= next_level[TOTAL_BITS-1:0];
                prev_q[idx_q]   <= gate_now;
                active_q[idx_q] <= (next_state != ST_IDLE);
                out_q           <= next_level[TOTAL_BITS-1:0];
                out_voice_q     <= idx_q;
                out_valid_q     <= 1'b1;
                if (idx_q == LAST_VOICE) busy_q <= 1'b0;
                else                     idx_q  <= idx_q + VB'(1);
            end
        end
    end

    assign out       = out_q;
    assign out_voice = out_voice_q;
    assign out_valid = out_valid_q;
    assign active    = active_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adsr_poly.sv
// tb_adsr_poly: directed checks of adsr_poly with four voices and Q16.32 levels.
module tb_adsr_poly;

    localparam int TB = 48;
    localparam int FB = 32;
    localparam int NV = 4;

    localparam logic signed [TB-1:0] ONE  = 48'sh1_0000_0000;
    localparam logic signed [TB-1:0] HALF = 48'sh0_8000_0000;
    localparam logic signed [TB-1:0] QTR  = 48'sh0_4000_0000;
    // Rates rounded up so the nominal 100/50/25-sample ramps land exactly.
    localparam logic signed [TB-1:0] RA   = 48'sd42949673;
    localparam logic signed [TB-1:0] RD   = 48'sd85899346;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [TB-1:0] a, d, s, r;
    logic [NV-1:0]        gate;
    logic                 retrigger;
    logic                 tick;
    logic signed [TB-1:0] out;
    logic [1:0]           out_voice;
    logic                 out_valid;
    logic [NV-1:0]        active;
    logic                 busy;
    logic                 overrun;

    int checks = 0;
    int errors = 0;

    logic signed [TB-1:0] lvl [NV];
    int                   valid_cnt;
    int                   busy_cnt;
    bit                   order_ok;

    adsr_poly #(.TOTAL_BITS(TB), .FRACTIONAL_BITS(FB), .VOICES(NV)) dut (
        .clk(clk), .reset(reset), .a(a), .d(d), .s(s), .r(r),
        .gate(gate), .retrigger(retrigger), .tick(tick),
        .out(out), .out_voice(out_voice), .out_valid(out_valid),
        .active(active), .busy(busy), .overrun(overrun)
    );

    // clock
    always #5 clk = ~clk;

    // One tick pulse, then observe the whole sweep at negedges.
    task automatic do_tick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        valid_cnt = 0; busy_cnt = 0; order_ok = 1'b1;
        for (int i = 0; i < NV + 2; i++) begin
            if (busy) busy_cnt++;
            if (out_valid) begin
                if (out_voice != 2'(valid_cnt)) order_ok = 1'b0;
                lvl[out_voice] = out;
                valid_cnt++;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (out !== '0) begin errors++; $display("FAIL reset_out: got %0d expected 0", out); end
        checks++; if (out_voice !== 2'd0) begin errors++; $display("FAIL reset_out_voice: got %0d expected 0", out_voice); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b expected 0000", active); end
        checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_busy_overrun: got %b%b expected 00", busy, overrun); end
    endtask

    task automatic test_idle_sweep();
        gate = 4'b0000;
        for (int v = 0; v < NV; v++) lvl[v] = 48'sd1;
        do_tick();
        checks++; if (valid_cnt != 4) begin errors++; $display("FAIL idle_valid_count: got %0d expected 4", valid_cnt); end
        checks++; if (busy_cnt != 4) begin errors++; $display("FAIL idle_busy_count: got %0d expected 4", busy_cnt); end
        checks++; if (!order_ok) begin errors++; $display("FAIL idle_voice_order: got out of order expected 0..3"); end
        for (int v = 0; v < NV; v++) begin
            checks++; if (lvl[v] !== '0) begin errors++; $display("FAIL idle_level%0d: got %0d expected 0", v, lvl[v]); end
        end
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL idle_active: got %b expected 0000", active); end
    endtask

    task automatic test_attack_decay();
        gate = 4'b0001; retrigger = 1'b1;
        do_ticks(99);
        checks++; if (lvl[0] !== 48'sd99 * RA) begin errors++; $display("FAIL attack99: got %0d expected %0d", lvl[0], 48'sd99 * RA); end
        checks++; if (active !== 4'b0001) begin errors++; $display("FAIL attack_active: got %b expected 0001", active); end
        do_tick();
        checks++; if (lvl[0] !== ONE) begin errors++; $display("FAIL attack_peak: got %0d expected %0d", lvl[0], ONE); end
        do_ticks(24);
        checks++; if (lvl[0] !== ONE - 48'sd24 * RD) begin errors++; $display("FAIL decay24: got %0d expected %0d", lvl[0], ONE - 48'sd24 * RD); end
        do_tick();
        checks++; if (lvl[0] !== HALF) begin errors++; $display("FAIL decay_to_sustain: got %0d expected %0d", lvl[0], HALF); end
        do_tick();
        checks++; if (lvl[0] !== HALF) begin errors++; $display("FAIL sustain_hold: got %0d expected %0d", lvl[0], HALF); end
        checks++; if (lvl[1] !== '0 || lvl[2] !== '0 || lvl[3] !== '0) begin errors++; $display("FAIL others_silent: got %0d %0d %0d expected 0", lvl[1], lvl[2], lvl[3]); end
    endtask

    task automatic test_release();
        gate = 4'b0000;
        do_tick();
        checks++; if (lvl[0] !== HALF - RA) begin errors++; $display("FAIL release1: got %0d expected %0d", lvl[0], HALF - RA); end
        do_ticks(48);
        checks++; if (lvl[0] !== HALF - 48'sd49 * RA) begin errors++; $display("FAIL release49: got %0d expected %0d", lvl[0], HALF - 48'sd49 * RA); end
        checks++; if (active !== 4'b0001) begin errors++; $display("FAIL release_active: got %b expected 0001", active); end
        do_tick();
        checks++; if (lvl[0] !== '0) begin errors++; $display("FAIL release_end: got %0d expected 0", lvl[0]); end
        checks++; if (active !== 4'b0000) begin errors++; $display("FAIL release_idle: got %b expected 0000", active); end
    endtask

    task automatic test_retrigger();
        s = QTR + RA;
        gate = 4'b0010; retrigger = 1'b1;
        do_ticks(140);
        checks++; if (lvl[1] !== QTR + RA) begin errors++; $display("FAIL retrig_sustain: got %0d expected %0d", lvl[1], QTR + RA); end
        gate = 4'b0000; do_tick();
        checks++; if (lvl[1] !== QTR) begin errors++; $display("FAIL retrig_release: got %0d expected %0d", lvl[1], QTR); end
        gate = 4'b0010; do_tick();
        checks++; if (lvl[1] !== RA) begin errors++; $display("FAIL retrig_restart: got %0d expected %0d", lvl[1], RA); end
        do_ticks(140);
        checks++; if (lvl[1] !== QTR + RA) begin errors++; $display("FAIL legato_sustain: got %0d expected %0d", lvl[1], QTR + RA); end
        gate = 4'b0000; do_tick();
        gate = 4'b0010; retrigger = 1'b0; do_tick();
        checks++; if (lvl[1] !== QTR + RA) begin errors++; $display("FAIL legato_continue: got %0d expected %0d", lvl[1], QTR + RA); end
        checks++; if (lvl[0] !== '0) begin errors++; $display("FAIL retrig_voice0: got %0d expected 0", lvl[0]); end
    endtask

    task automatic test_clamp_overrun();
        int vc;
        a = '0; s = -48'sd5; gate = 4'b0100;
        do_tick();
        checks++; if (lvl[2] !== ONE) begin errors++; $display("FAIL zero_attack: got %0d expected %0d", lvl[2], ONE); end
        do_tick();
        checks++; if (lvl[2] !== ONE - RD) begin errors++; $display("FAIL clamp_decay1: got %0d expected %0d", lvl[2], ONE - RD); end
        do_ticks(49);
        checks++; if (lvl[2] !== '0) begin errors++; $display("FAIL clamp_floor: got %0d expected 0", lvl[2]); end
        checks++; if (active !== 4'b0100) begin errors++; $display("FAIL clamp_active: got %b expected 0100", active); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b expected 0", overrun); end
        // Hold tick for two edges: the second lands while busy.
        @(negedge clk); tick = 1'b1;
        @(negedge clk);
        @(negedge clk); tick = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        vc = 0;
        for (int i = 0; i < 7; i++) begin
            if (out_valid) vc++;
            @(negedge clk);
        end
        checks++; if (vc != 4 || busy !== 1'b0) begin errors++; $display("FAIL overrun_sweep: got %0d valid busy %b expected 4 valid busy 0", vc, busy); end
        do_tick();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        checks++; if (lvl[2] !== '0) begin errors++; $display("FAIL clamp_hold: got %0d expected 0", lvl[2]); end
    endtask

    task automatic test_reset_mid_sweep();
        int vc;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_voice !== 2'd1) begin errors++; $display("FAIL mid_voice1: got valid %b voice %0d expected valid 1 voice 1", out_valid, out_voice); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got %b%b%b expected 000", out_valid, busy, overrun); end
        checks++; if (out !== '0 || out_voice !== 2'd0 || active !== 4'b0000) begin errors++; $display("FAIL mid_reset_outs: got %0d %0d %b expected 0 0 0000", out, out_voice, active); end
        reset = 1'b0;
        vc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || busy) vc++;
        end
        checks++; if (vc != 0) begin errors++; $display("FAIL mid_abort: got %0d active cycles expected 0", vc); end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; gate = '0; retrigger = 1'b1;
        a = RA; d = RD; s = HALF; r = RA;
        test_reset();
        test_idle_sweep();
        test_attack_decay();
        test_release();
        test_retrigger();
        test_clamp_overrun();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
